// File: rtl/button_encoder_pkg.sv
// Shared constants, encoder state type and small bit-vector helpers for button_encoder.
package button_encoder_pkg;

  localparam logic [15:0] DEBOUNCE_TIME = 16'd50000;
  localparam int          NUM_COLOURS   = 4;

  typedef enum logic [1:0] {
    ENC_IDLE_S    = 2'd0,
    ENC_PRESSED_S = 2'd1,
    ENC_MULTI_S   = 2'd2
  } enc_state_e;

  function automatic logic [2:0] count_set(input logic [NUM_COLOURS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLOURS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  function automatic logic [1:0] first_set(input logic [NUM_COLOURS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_COLOURS - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_encoder_if.sv
// Board-side pins and controller-side outputs of button_encoder, plus encoder state for debug.
// IN/IN_VALID is a level-held valid with no ready: IN is meaningful only while IN_VALID=1,
// and IN_VALID stays high for as long as the accepted button remains (debounced) pressed.
interface button_encoder_if;
  import button_encoder_pkg::*;

  logic [3:0] BTN;
  logic       START_BTN;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       START_GAME;
  enc_state_e dbg_state;

  modport master (
    input  BTN, START_BTN,
    output IN, IN_VALID, START_GAME, dbg_state
  );

  modport slave (
    output BTN, START_BTN,
    input  IN, IN_VALID, START_GAME, dbg_state
  );

endinterface

// File: rtl/button_encoder_debounce.sv
// One input: 2-flop synchronizer followed by a stable-run counter debouncer.
module button_encoder_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter measures how long the synchronized value has disagreed with the stable level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_encoder.sv
// Conditions four colour buttons and a start button into IN/IN_VALID and START_GAME.
// Build option: define BUTTON_ACTIVE_LOW_EN for pull-up (active-low) buttons.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_TIME,
  parameter int          CNT_W           = 16
) (
  input logic              CLK,
  input logic              RST_N,
  button_encoder_if.master bus
);

  logic [4:0]             raw_vec;
  logic [4:0]             lvl_vec;
  logic [NUM_COLOURS-1:0] d_vec;

`ifdef BUTTON_ACTIVE_LOW_EN
  assign raw_vec = ~{bus.START_BTN, bus.BTN};
`else
  assign raw_vec = {bus.START_BTN, bus.BTN};
`endif

  for (genvar i = 0; i < 5; i++) begin : g_deb
    button_encoder_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .CLK   (CLK),
      .RST_N (RST_N),
      .raw   (raw_vec[i]),
      .level (lvl_vec[i])
    );
  end

  assign d_vec = lvl_vec[NUM_COLOURS-1:0];

  enc_state_e state_q, state_d;
  logic [1:0] in_q, in_d;
  logic       valid_q, valid_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ENC_IDLE_S;
      in_q    <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      valid_q <= valid_d;
    end
  end

  // First single press wins; anything ambiguous parks in MULTI until every button is released.
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    valid_d = valid_q;
    unique case (state_q)
      ENC_IDLE_S: begin
        valid_d = 1'b0;
        if (count_set(d_vec) == 3'd1) begin
          in_d    = first_set(d_vec);
          valid_d = 1'b1;
          state_d = ENC_PRESSED_S;
        end else if (d_vec != '0) begin
          state_d = ENC_MULTI_S;
        end
      end
      ENC_PRESSED_S: begin
        if (!d_vec[in_q]) begin
          valid_d = 1'b0;
          state_d = (d_vec != '0) ? ENC_MULTI_S : ENC_IDLE_S;
        end
      end
      ENC_MULTI_S: begin
        valid_d = 1'b0;
        if (d_vec == '0) state_d = ENC_IDLE_S;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ENC_IDLE_S;
      end
    endcase
  end

  assign bus.IN         = in_q;
  assign bus.IN_VALID   = valid_q;
  assign bus.START_GAME = lvl_vec[4];
  assign bus.dbg_state  = state_q;

endmodule
